stream_error_monitor: RTL and testbench
=======================================

# stream_error_monitor

Synthesizable, parametrised successor to the single-port x→y comparison flow: checks a multi-channel DUT output stream against a reference stream each valid cycle, computes exact signed absolute error per channel, and accumulates run statistics (sample count, mismatch count, max error with location, error sum) inside a start/stop measurement window. It sits beside a multi-lane datapath under test, in simulation or on silicon, so error statistics no longer need a bench-side file compare.

## Interface
- DATA_BITS, 16: width of each signed two's-complement channel sample
- CHANNELS, 4: number of parallel lanes compared per cycle
- TOL, 0: unsigned abs-error threshold; errors strictly greater than TOL count as mismatches
- COUNT_BITS, 32: width of sample, mismatch and index counters
- SUM_BITS, 48: width of the abs-error accumulator
---
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  open the measurement window; clears all statistics
- stop  in  1  close the window; in-flight samples drain
- in_valid  in  1  ref_y/dut_y hold a sample this cycle
- ref_y  in  CHANNELS*DATA_BITS  expected outputs, channel c at bits [c*DATA_BITS +: DATA_BITS]
- dut_y  in  CHANNELS*DATA_BITS  DUT outputs, same packing
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE; statistics final
- sample_count  out  COUNT_BITS  valid samples accepted in window
- mismatch_count  out  COUNT_BITS  channel-samples with abs error > TOL
- max_abs_err  out  DATA_BITS  largest unsigned abs error seen
- max_err_channel  out  $clog2(CHANNELS) (min 1)  channel of max_abs_err
- max_err_index  out  COUNT_BITS  sample index (0-based) of max_abs_err
- sum_abs_err  out  SUM_BITS  saturating sum of all channel abs errors

## Operation
- States: IDLE → RUN on start; RUN → DRAIN on stop; DRAIN → DONE after LATENCY cycles; DONE → RUN on start; any → IDLE on rst.
- start in RUN or DRAIN: restart (clear stats, go/stay RUN); samples already in the pipeline are discarded. start and stop in the same cycle: start wins.
- Samples accepted only when in_valid and state is RUN (including the cycle stop is sampled). in_valid in IDLE/DRAIN/DONE is ignored.
- Per channel: diff = ref − dut computed sign-extended in DATA_BITS+1 bits (no wrap); abs = |diff|, exact in DATA_BITS unsigned bits (max 2^DATA_BITS − 1, e.g. ref=32767, dut=−32768 → 65535).
- Per sample: sum of CHANNELS abs values; mismatch popcount; max across channels, ties to the lowest channel.
- Running max updates only on strictly greater value, so the earliest occurrence is kept.
- sample_count, mismatch_count, sum_abs_err saturate at all-ones; never wrap.
- Statistics remain stable and readable in DONE and IDLE until the next start or rst.

## Timing
- Reset values: busy=0, done=0, all statistics 0, state IDLE.
- Pipeline: S1 register diffs, S2 register abs values, S3 register per-sample reduction; statistics update on the clock edge ending S3. LATENCY = 3: a sample accepted on edge n is reflected in outputs after edge n+3.
- sample_count increments with the S3 update, not on acceptance.
- done rises exactly LATENCY cycles after the edge that samples stop; busy falls the same edge.
- Full throughput: one sample per cycle, no back-pressure.
- rst mid-run flushes the pipeline and clears everything on the same edge.

## Structure
- Package stream_error_monitor_pkg: state enum (IDLE, RUN, DRAIN, DONE), LATENCY constant, saturating-add function.
- Sub-module abs_diff (parameter DATA_BITS): one channel, ref/dut in, registered DATA_BITS-wide abs out (covers S1–S2); instantiated CHANNELS times.
- Top holds the reduction stage, FSM, drain counter and accumulators.

## Test plan
- Reset then idle: all outputs 0, busy=0, done=0; in_valid pulses in IDLE leave sample_count=0.
- CHANNELS=4, TOL=0: start, 3 samples ref=dut → stop → done after 3 cycles, sample_count=3, mismatch_count=0, sum=0.
- Extremes: ref=32767, dut=−32768 on ch2 at sample 5 → max_abs_err=65535, max_err_channel=2, max_err_index=5, no overflow.
- TOL=2 with errors {1,2,3,−4} on one sample → mismatch_count=2, sum_abs_err=10; tie errors 7 on ch1 and ch3 → channel 1.
- Saturation: COUNT_BITS=4, 20 valid samples → sample_count=15; stop with valid on same cycle → that sample counted.
- Restart: start during DRAIN → stats cleared, in-flight samples dropped, busy stays 1; rst mid-RUN → all outputs 0 next cycle.

Source files
------------

// File: rtl/stream_error_monitor_pkg.sv
// Shared types and helpers for the stream error monitor: FSM state encoding,
// pipeline depth and a saturating adder used by the statistics accumulators.
package stream_error_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Edges between sample acceptance and the statistics update.
  localparam int LATENCY = 3;

  // Adds two zero-extended operands and clamps the result to a bits-wide all-ones value.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned bits);
    logic [64:0] sum;
    logic [64:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = (65'd1 << bits) - 65'd1;
    if (sum > limit) begin
      return limit[63:0];
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/stream_error_monitor_abs_diff.sv
// One channel of the comparison pipeline: S1 registers the widened difference,
// S2 registers its exact unsigned magnitude.
module abs_diff #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] ref_y,
  input  logic [DATA_BITS-1:0] dut_y,
  output logic [DATA_BITS-1:0] abs_err
);

  logic [DATA_BITS:0]   diff_next;
  logic [DATA_BITS:0]   diff_reg;
  logic [DATA_BITS-1:0] abs_next;
  logic [DATA_BITS-1:0] abs_reg;

  // One extra bit holds any difference of two DATA_BITS samples without wrapping.
  assign diff_next = {ref_y[DATA_BITS-1], ref_y} - {dut_y[DATA_BITS-1], dut_y};

  // The magnitude never exceeds 2^DATA_BITS-1, so negating the low bits is exact.
  always_comb begin
    abs_next = diff_reg[DATA_BITS-1:0];
    if (diff_reg[DATA_BITS]) begin
      abs_next = ~diff_reg[DATA_BITS-1:0] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_reg <= '0;
      abs_reg  <= '0;
    end else begin
      diff_reg <= diff_next;
      abs_reg  <= abs_next;
    end
  end

  assign abs_err = abs_reg;

endmodule

// File: rtl/stream_error_monitor.sv
// Compares a multi-lane DUT stream with a reference stream and accumulates error
// statistics inside a start/stop window; stats land LATENCY edges after acceptance.
module stream_error_monitor
  import stream_error_monitor_pkg::*;
#(
  parameter int          DATA_BITS  = 16,
  parameter int          CHANNELS   = 4,
  parameter int unsigned TOL        = 0,
  parameter int          COUNT_BITS = 32,
  parameter int          SUM_BITS   = 48,
  localparam int         CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          in_valid,
  input  logic [CHANNELS*DATA_BITS-1:0] ref_y,
  input  logic [CHANNELS*DATA_BITS-1:0] dut_y,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_BITS-1:0]         sample_count,
  output logic [COUNT_BITS-1:0]         mismatch_count,
  output logic [DATA_BITS-1:0]          max_abs_err,
  output logic [CH_BITS-1:0]            max_err_channel,
  output logic [COUNT_BITS-1:0]         max_err_index,
  output logic [SUM_BITS-1:0]           sum_abs_err
);

  localparam int RED_BITS   = DATA_BITS + $clog2(CHANNELS) + 1;
  localparam int POP_BITS   = $clog2(CHANNELS + 1);
  localparam int DRAIN_BITS = $clog2(LATENCY);
  localparam logic [DATA_BITS-1:0] TOL_D = DATA_BITS'(TOL);

  state_t                state_reg, state_next;
  logic [DRAIN_BITS-1:0] drain_reg, drain_next;

  logic accept;
  logic v_s1_reg, v_s2_reg, v_s3_reg;

  logic [DATA_BITS-1:0] abs_err [CHANNELS];

  logic [RED_BITS-1:0]  red_sum_next, red_sum_reg;
  logic [POP_BITS-1:0]  red_pop_next, red_pop_reg;
  logic [DATA_BITS-1:0] red_max_next, red_max_reg;
  logic [CH_BITS-1:0]   red_ch_next, red_ch_reg;

  logic [COUNT_BITS-1:0] sample_count_reg;
  logic [COUNT_BITS-1:0] mismatch_count_reg;
  logic [DATA_BITS-1:0]  max_abs_err_reg;
  logic [CH_BITS-1:0]    max_err_channel_reg;
  logic [COUNT_BITS-1:0] max_err_index_reg;
  logic [SUM_BITS-1:0]   sum_abs_err_reg;

  // A start cycle never accepts: it opens (or reopens) the window for later cycles.
  assign accept = in_valid && (state_reg == RUN) && !start;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      abs_diff #(
        .DATA_BITS(DATA_BITS)
      ) u_abs_diff (
        .clk    (clk),
        .rst    (rst),
        .ref_y  (ref_y[gi*DATA_BITS +: DATA_BITS]),
        .dut_y  (dut_y[gi*DATA_BITS +: DATA_BITS]),
        .abs_err(abs_err[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || start) begin
      v_s1_reg <= 1'b0;
      v_s2_reg <= 1'b0;
      v_s3_reg <= 1'b0;
    end else begin
      v_s1_reg <= accept;
      v_s2_reg <= v_s1_reg;
      v_s3_reg <= v_s2_reg;
    end
  end

  // Per-sample reduction; strict compare keeps the lowest channel on ties.
  always_comb begin
    red_sum_next = '0;
    red_pop_next = '0;
    red_max_next = abs_err[0];
    red_ch_next  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      red_sum_next = red_sum_next + RED_BITS'(abs_err[c]);
      if (abs_err[c] > TOL_D) begin
        red_pop_next = red_pop_next + POP_BITS'(1);
      end
      if (abs_err[c] > red_max_next) begin
        red_max_next = abs_err[c];
        red_ch_next  = CH_BITS'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_sum_reg <= '0;
      red_pop_reg <= '0;
      red_max_reg <= '0;
      red_ch_reg  <= '0;
    end else if (v_s2_reg) begin
      red_sum_reg <= red_sum_next;
      red_pop_reg <= red_pop_next;
      red_max_reg <= red_max_next;
      red_ch_reg  <= red_ch_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (stop) begin
            state_next = DRAIN;
            drain_next = DRAIN_BITS'(LATENCY - 1);
          end
        end
        DRAIN: begin
          if (drain_reg == '0) begin
            state_next = DONE;
          end else begin
            drain_next = drain_reg - 1'b1;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
    end
  end

  // The max index is the count of samples already folded in, i.e. 0-based.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sample_count_reg    <= '0;
      mismatch_count_reg  <= '0;
      max_abs_err_reg     <= '0;
      max_err_channel_reg <= '0;
      max_err_index_reg   <= '0;
      sum_abs_err_reg     <= '0;
    end else if (v_s3_reg) begin
      sample_count_reg   <= COUNT_BITS'(sat_add(64'(sample_count_reg), 64'd1, COUNT_BITS));
      mismatch_count_reg <= COUNT_BITS'(sat_add(64'(mismatch_count_reg), 64'(red_pop_reg),
                                                COUNT_BITS));
      sum_abs_err_reg    <= SUM_BITS'(sat_add(64'(sum_abs_err_reg), 64'(red_sum_reg),
                                              SUM_BITS));
      if (red_max_reg > max_abs_err_reg) begin
        max_abs_err_reg     <= red_max_reg;
        max_err_channel_reg <= red_ch_reg;
        max_err_index_reg   <= sample_count_reg;
      end
    end
  end

  assign busy            = (state_reg == RUN) || (state_reg == DRAIN);
  assign done            = (state_reg == DONE);
  assign sample_count    = sample_count_reg;
  assign mismatch_count  = mismatch_count_reg;
  assign max_abs_err     = max_abs_err_reg;
  assign max_err_channel = max_err_channel_reg;
  assign max_err_index   = max_err_index_reg;
  assign sum_abs_err     = sum_abs_err_reg;

endmodule

// File: tb/tb_stream_error_monitor.sv
// Directed bench for stream_error_monitor: default, TOL=2 and COUNT_BITS=4
// instances share one stimulus stream; expected values are hand-computed.
module tb_stream_error_monitor;

  localparam int DB = 16;
  localparam int CH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, in_valid;
  logic [CH*DB-1:0] ref_y, dut_y;

  logic        busy, done;
  logic [31:0] sample_count, mismatch_count, max_err_index;
  logic [15:0] max_abs_err;
  logic [1:0]  max_err_channel;
  logic [47:0] sum_abs_err;

  logic        t_busy, t_done;
  logic [31:0] t_sample_count, t_mismatch_count, t_max_err_index;
  logic [15:0] t_max_abs_err;
  logic [1:0]  t_max_err_channel;
  logic [47:0] t_sum_abs_err;

  logic        s_busy, s_done;
  logic [3:0]  s_sample_count, s_mismatch_count, s_max_err_index;
  logic [15:0] s_max_abs_err;
  logic [1:0]  s_max_err_channel;
  logic [47:0] s_sum_abs_err;

  int n_checks = 0;
  int n_fail   = 0;

  stream_error_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .ref_y(ref_y), .dut_y(dut_y), .busy(busy), .done(done),
    .sample_count(sample_count), .mismatch_count(mismatch_count),
    .max_abs_err(max_abs_err), .max_err_channel(max_err_channel),
    .max_err_index(max_err_index), .sum_abs_err(sum_abs_err)
  );

  stream_error_monitor #(.TOL(2)) u_tol (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .ref_y(ref_y), .dut_y(dut_y), .busy(t_busy), .done(t_done),
    .sample_count(t_sample_count), .mismatch_count(t_mismatch_count),
    .max_abs_err(t_max_abs_err), .max_err_channel(t_max_err_channel),
    .max_err_index(t_max_err_index), .sum_abs_err(t_sum_abs_err)
  );

  stream_error_monitor #(.COUNT_BITS(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .ref_y(ref_y), .dut_y(dut_y), .busy(s_busy), .done(s_done),
    .sample_count(s_sample_count), .mismatch_count(s_mismatch_count),
    .max_abs_err(s_max_abs_err), .max_err_channel(s_max_err_channel),
    .max_err_index(s_max_err_index), .sum_abs_err(s_sum_abs_err)
  );

  function automatic logic [63:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [15:0] a, b, c, d;
    a = c0[15:0];
    b = c1[15:0];
    c = c2[15:0];
    d = c3[15:0];
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_window();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic close_and_drain();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%0b done=%0b expected 0 0", busy, done);
    end
    n_checks++;
    if ({sample_count, mismatch_count, max_abs_err, max_err_channel, max_err_index,
         sum_abs_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: count=%0d mism=%0d max=%0d sum=%0d expected all 0",
               sample_count, mismatch_count, max_abs_err, sum_abs_err);
    end
    in_valid = 1'b1;
    ref_y = pack4(5, 5, 5, 5);
    dut_y = '0;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (sample_count !== 32'd0 || sum_abs_err !== 48'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid_ignored: count=%0d sum=%0d busy=%0b expected 0 0 0",
               sample_count, sum_abs_err, busy);
    end
  endtask

  task automatic test_match();
    open_window();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: busy=%0b expected 1", busy);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      ref_y = pack4(100 * i, -7, 32767, -32768);
      dut_y = ref_y;
      tick();
    end
    in_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_early: done=%0b busy=%0b expected 0 1", done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_latency: done=%0b busy=%0b expected 1 0", done, busy);
    end
    n_checks++;
    if (sample_count !== 32'd3 || mismatch_count !== 32'd0 || sum_abs_err !== 48'd0) begin
      n_fail++;
      $display("FAIL match_stats: count=%0d mism=%0d sum=%0d expected 3 0 0",
               sample_count, mismatch_count, sum_abs_err);
    end
    in_valid = 1'b1;
    ref_y = pack4(9, 9, 9, 9);
    dut_y = '0;
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (sample_count !== 32'd3 || sum_abs_err !== 48'd0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_valid_ignored: count=%0d sum=%0d done=%0b expected 3 0 1",
               sample_count, sum_abs_err, done);
    end
  endtask

  task automatic test_extremes();
    open_window();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      if (i < 5) begin
        ref_y = pack4(1, 0, 0, 0);
        dut_y = '0;
      end else begin
        ref_y = pack4(0, 0, 32767, 0);
        dut_y = pack4(0, 0, -32768, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    close_and_drain();
    n_checks++;
    if (max_abs_err !== 16'd65535 || max_err_channel !== 2'd2 || max_err_index !== 32'd5) begin
      n_fail++;
      $display("FAIL extreme_max: max=%0d ch=%0d idx=%0d expected 65535 2 5",
               max_abs_err, max_err_channel, max_err_index);
    end
    n_checks++;
    if (sum_abs_err !== 48'd65540 || mismatch_count !== 32'd6 || sample_count !== 32'd6) begin
      n_fail++;
      $display("FAIL extreme_sum: sum=%0d mism=%0d count=%0d expected 65540 6 6",
               sum_abs_err, mismatch_count, sample_count);
    end
    n_checks++;
    if (t_mismatch_count !== 32'd1 || t_sum_abs_err !== 48'd65540) begin
      n_fail++;
      $display("FAIL extreme_tol: mism=%0d sum=%0d expected 1 65540",
               t_mismatch_count, t_sum_abs_err);
    end
  endtask

  task automatic test_tol_and_ties();
    open_window();
    in_valid = 1'b1;
    ref_y = pack4(1, 2, 3, -4);
    dut_y = '0;
    tick();
    ref_y = pack4(0, 7, 0, 0);
    dut_y = pack4(0, 0, 0, 7);
    tick();
    ref_y = pack4(7, 0, 0, 0);
    dut_y = '0;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (t_mismatch_count !== 32'd2 || t_sum_abs_err !== 48'd10) begin
      n_fail++;
      $display("FAIL tol_first: mism=%0d sum=%0d expected 2 10", t_mismatch_count, t_sum_abs_err);
    end
    n_checks++;
    if (t_max_abs_err !== 16'd4 || t_max_err_channel !== 2'd3) begin
      n_fail++;
      $display("FAIL tol_first_max: max=%0d ch=%0d expected 4 3", t_max_abs_err, t_max_err_channel);
    end
    close_and_drain();
    n_checks++;
    if (t_max_abs_err !== 16'd7 || t_max_err_channel !== 2'd1 || t_max_err_index !== 32'd1) begin
      n_fail++;
      $display("FAIL tie_lowest_earliest: max=%0d ch=%0d idx=%0d expected 7 1 1",
               t_max_abs_err, t_max_err_channel, t_max_err_index);
    end
    n_checks++;
    if (t_mismatch_count !== 32'd5 || t_sum_abs_err !== 48'd31) begin
      n_fail++;
      $display("FAIL tol_total: mism=%0d sum=%0d expected 5 31", t_mismatch_count, t_sum_abs_err);
    end
    n_checks++;
    if (mismatch_count !== 32'd7) begin
      n_fail++;
      $display("FAIL tol0_mismatch: mism=%0d expected 7", mismatch_count);
    end
  endtask

  task automatic test_saturation();
    open_window();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      stop = (i == 19);
      ref_y = (i == 19) ? pack4(100, 1, 1, 1) : pack4(1, 1, 1, 1);
      dut_y = '0;
      tick();
    end
    in_valid = 1'b0;
    stop = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (s_sample_count !== 4'd15 || s_mismatch_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_counts: count=%0d mism=%0d expected 15 15",
               s_sample_count, s_mismatch_count);
    end
    n_checks++;
    if (done !== 1'b1 || sample_count !== 32'd20 || mismatch_count !== 32'd80) begin
      n_fail++;
      $display("FAIL stop_with_valid: done=%0b count=%0d mism=%0d expected 1 20 80",
               done, sample_count, mismatch_count);
    end
    n_checks++;
    if (max_abs_err !== 16'd100 || max_err_index !== 32'd19 || sum_abs_err !== 48'd179) begin
      n_fail++;
      $display("FAIL stop_sample_stats: max=%0d idx=%0d sum=%0d expected 100 19 179",
               max_abs_err, max_err_index, sum_abs_err);
    end
  endtask

  task automatic test_restart();
    open_window();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      ref_y = pack4(5, 0, 0, 0);
      dut_y = '0;
      tick();
    end
    in_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || sample_count !== 32'd2) begin
      n_fail++;
      $display("FAIL drain_partial: busy=%0b count=%0d expected 1 2", busy, sample_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 32'd0 || sum_abs_err !== 48'd0) begin
      n_fail++;
      $display("FAIL restart_clear: busy=%0b done=%0b count=%0d sum=%0d expected 1 0 0 0",
               busy, done, sample_count, sum_abs_err);
    end
    repeat (4) tick();
    n_checks++;
    if (sample_count !== 32'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_dropped: count=%0d busy=%0b expected 0 1", sample_count, busy);
    end
  endtask

  task automatic test_rst_mid_run();
    in_valid = 1'b1;
    ref_y = pack4(9, 0, 0, 0);
    dut_y = '0;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (sample_count !== 32'd2 || max_abs_err !== 16'd9) begin
      n_fail++;
      $display("FAIL run_before_rst: count=%0d max=%0d expected 2 9", sample_count, max_abs_err);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        {sample_count, mismatch_count, max_abs_err, max_err_channel, max_err_index,
         sum_abs_err} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_run: busy=%0b count=%0d max=%0d sum=%0d expected all 0",
               busy, sample_count, max_abs_err, sum_abs_err);
    end
    rst = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (sample_count !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flush: count=%0d busy=%0b expected 0 0", sample_count, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    in_valid = 1'b0;
    ref_y = '0;
    dut_y = '0;
    test_reset();
    test_match();
    test_extremes();
    test_tol_and_ties();
    test_saturation();
    test_restart();
    test_rst_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
